// File: rtl/irq_controller_cpu.sv
// Memory-mapped interrupt controller: N sources with per-channel enable, edge/level
// mode, polarity, W1C pending, software trigger and a fixed-priority active-ID readout.
module irq_controller_cpu #(
  parameter int BaseAddress     = 0,
  parameter int address_width   = 32,
  parameter int data_width      = 32,
  parameter int Address_Wording = 4,
  parameter int NumSources      = 8,
  parameter int SyncStages      = 2
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [address_width-1:0]    address_i,
  input  logic [data_width-1:0]       data_i,
  input  logic                        rd_wr_i,
  output logic [data_width-1:0]       data_o,
  input  logic [NumSources-1:0]       irq_src_i,
  output logic                        irq_o,
  output logic [$clog2(NumSources):0] irq_id_o
);
  localparam int ID_W   = $clog2(NumSources) + 1;
  localparam int N_REGS = 6;

  if (NumSources < 1 || NumSources >= data_width) begin : g_bad_cfg
    $error("irq_controller_cpu: NumSources must lie in 1..data_width-1");
  end

  logic [NumSources-1:0] pending_r;
  logic [NumSources-1:0] enable_r;
  logic [NumSources-1:0] mode_r;
  logic [NumSources-1:0] polarity_r;
  logic [NumSources-1:0] prev_r;
  logic [NumSources-1:0] sync_s;
  logic [NumSources-1:0] cond_s;
  logic [NumSources-1:0] pend_next_s;
  logic [NumSources-1:0] act_s;
  logic [N_REGS-1:0]     match_s;
  logic [N_REGS-1:0]     wr_s;
  logic                  hit_s;
  logic [2:0]            reg_idx_s;
  logic [ID_W-1:0]       idx_s;
  logic [ID_W-1:0]       id_next_s;
  logic [data_width-1:0] rdata_s;
  logic                  unused_data_s;

  assign unused_data_s = ^data_i[data_width-1:NumSources];

  if (SyncStages > 0) begin : g_sync
    logic [SyncStages-1:0][NumSources-1:0] sync_r;
    // Synchroniser chain for possibly asynchronous sources
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        sync_r <= '0;
      end else begin
        sync_r[0] <= irq_src_i;
        for (int j = 1; j < SyncStages; j++) begin
          sync_r[j] <= sync_r[j-1];
        end
      end
    end
    assign sync_s = sync_r[SyncStages-1];
  end else begin : g_nosync
    assign sync_s = irq_src_i;
  end

  assign cond_s = sync_s ^ polarity_r;
  assign act_s  = pending_r & enable_r;

  // Address decode; register addresses are distinct so the OR-merge of indices is exact
  always_comb begin
    reg_idx_s = 3'd0;
    for (int k = 0; k < N_REGS; k++) begin
      match_s[k] = (address_i == address_width'(BaseAddress + k * Address_Wording));
      reg_idx_s  = reg_idx_s | (match_s[k] ? 3'(k) : 3'd0);
    end
    hit_s = |match_s;
    wr_s  = match_s & {N_REGS{rd_wr_i}};
  end

  // Next pending state: edge channels latch (set beats W1C), level channels follow input
  always_comb begin
    pend_next_s = pending_r;
    for (int i = 0; i < NumSources; i++) begin
      if (mode_r[i]) begin
        pend_next_s[i] = (cond_s[i] & ~prev_r[i]) | (wr_s[5] & data_i[i])
                       | (pending_r[i] & ~(wr_s[0] & data_i[i]));
      end else begin
        pend_next_s[i] = cond_s[i];
      end
    end
  end

  // Lowest-numbered active source wins
  always_comb begin
    idx_s = {ID_W{1'b0}};
    for (int i = NumSources - 1; i >= 0; i--) begin
      if (act_s[i]) begin
        idx_s = ID_W'(i);
      end else begin
        idx_s = idx_s;
      end
    end
    id_next_s           = idx_s;
    id_next_s[ID_W-1]   = |act_s;
  end

  // Read mux; ACTIVE moves the valid flag to the top data bit
  always_comb begin
    rdata_s = '0;
    if (hit_s) begin
      case (reg_idx_s)
        3'd0: rdata_s = data_width'(pending_r);
        3'd1: rdata_s = data_width'(enable_r);
        3'd2: rdata_s = data_width'(mode_r);
        3'd3: rdata_s = data_width'(polarity_r);
        3'd4: begin
          rdata_s               = data_width'(irq_id_o);
          rdata_s[ID_W-1]       = 1'b0;
          rdata_s[data_width-1] = irq_id_o[ID_W-1];
        end
        default: rdata_s = '0;
      endcase
    end else begin
      rdata_s = '0;
    end
  end

  // Register file, edge history and registered outputs
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pending_r  <= '0;
      enable_r   <= '0;
      mode_r     <= '0;
      polarity_r <= '0;
      prev_r     <= cond_s;
      data_o     <= '0;
      irq_o      <= 1'b0;
      irq_id_o   <= '0;
    end else begin
      pending_r <= pend_next_s;
      prev_r    <= cond_s;
      if (wr_s[1]) enable_r <= data_i[NumSources-1:0];
      if (wr_s[2]) mode_r <= data_i[NumSources-1:0];
      if (wr_s[3]) polarity_r <= data_i[NumSources-1:0];
      data_o    <= rdata_s;
      irq_o     <= |act_s;
      irq_id_o  <= id_next_s;
    end
  end

endmodule

// File: tb/tb_irq_controller_cpu.sv
// Self-checking bench for irq_controller_cpu: scenario tasks with a read-data scoreboard queue.
module tb_irq_controller_cpu;
  localparam logic [31:0] IDLE_ADDR = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] address = IDLE_ADDR;
  logic [31:0] data_w = 32'h0;
  logic        rd_wr = 1'b0;
  logic [31:0] data_rd;
  logic [7:0]  src = 8'h00;
  logic        irq;
  logic [3:0]  irq_id;

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] rd_q[$];

  always #5 clk = ~clk;

  irq_controller_cpu #(
    .BaseAddress(0), .address_width(32), .data_width(32),
    .Address_Wording(4), .NumSources(8), .SyncStages(2)
  ) dut (
    .clk_i(clk), .reset_i(reset), .address_i(address), .data_i(data_w),
    .rd_wr_i(rd_wr), .data_o(data_rd), .irq_src_i(src), .irq_o(irq), .irq_id_o(irq_id)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input int idx, input logic [31:0] val);
    address = 32'(idx * 4);
    data_w  = val;
    rd_wr   = 1'b1;
    tick();
    rd_wr   = 1'b0;
    data_w  = 32'h0;
    address = IDLE_ADDR;
  endtask

  task automatic issue_read(input int idx, input logic [31:0] exp);
    address = 32'(idx * 4);
    rd_wr   = 1'b0;
    rd_q.push_back(exp);
    tick();
    address = IDLE_ADDR;
  endtask

  task automatic test_reset();
    logic [31:0] e;
    repeat (3) tick();
    n_checks++;
    if ({irq, irq_id, data_rd} !== 37'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got irq=%b id=%h data=%h expected all 0", irq, irq_id, data_rd);
    end
    reset = 1'b0;
    tick();
    for (int k = 0; k < 7; k++) begin
      issue_read(k, 32'h0);
      e = rd_q.pop_front();
      n_checks++;
      if (data_rd !== e) begin
        n_fail++;
        $display("FAIL reset_reg%0d: got %h expected %h", k, data_rd, e);
      end
    end
    n_checks++;
    if (irq !== 1'b0 || irq_id !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_irq: got irq=%b id=%h expected 0/0", irq, irq_id);
    end
  endtask

  task automatic test_edge();
    logic [31:0] e;
    bus_write(1, 32'h08);
    bus_write(2, 32'h08);
    src[3] = 1'b1;
    tick();
    src[3] = 1'b0;
    tick();
    tick();
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL edge_irq_early: got %b expected 0", irq);
    end
    issue_read(0, 32'h08);
    e = rd_q.pop_front();
    n_checks++;
    if (data_rd !== e) begin
      n_fail++;
      $display("FAIL edge_pending: got %h expected %h", data_rd, e);
    end
    n_checks++;
    if (irq !== 1'b1 || irq_id !== 4'hB) begin
      n_fail++;
      $display("FAIL edge_irq: got irq=%b id=%h expected 1/b", irq, irq_id);
    end
    issue_read(4, 32'h8000_0003);
    e = rd_q.pop_front();
    n_checks++;
    if (data_rd !== e) begin
      n_fail++;
      $display("FAIL edge_active: got %h expected %h", data_rd, e);
    end
    bus_write(0, 32'h08);
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL edge_w1c_lag: got %b expected 1", irq);
    end
    tick();
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL edge_w1c_irq: got %b expected 0", irq);
    end
    issue_read(0, 32'h0);
    e = rd_q.pop_front();
    n_checks++;
    if (data_rd !== e) begin
      n_fail++;
      $display("FAIL edge_w1c_pending: got %h expected %h", data_rd, e);
    end
  endtask

  task automatic test_level();
    logic [31:0] e;
    bus_write(2, 32'h00);
    bus_write(1, 32'h02);
    bus_write(3, 32'h02);
    tick();
    issue_read(0, 32'h02);
    e = rd_q.pop_front();
    n_checks++;
    if (data_rd !== e) begin
      n_fail++;
      $display("FAIL level_pending: got %h expected %h", data_rd, e);
    end
    bus_write(0, 32'h02);
    issue_read(0, 32'h02);
    e = rd_q.pop_front();
    n_checks++;
    if (data_rd !== e) begin
      n_fail++;
      $display("FAIL level_w1c_held: got %h expected %h", data_rd, e);
    end
    src[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      issue_read(0, (k < 3) ? 32'h02 : 32'h00);
      e = rd_q.pop_front();
      n_checks++;
      if (data_rd !== e) begin
        n_fail++;
        $display("FAIL level_release%0d: got %h expected %h", k, data_rd, e);
      end
    end
    src[1] = 1'b0;
    bus_write(3, 32'h00);
    repeat (4) tick();
    bus_write(1, 32'h00);
  endtask

  task automatic test_priority();
    bus_write(1, 32'hFF);
    bus_write(2, 32'hFF);
    src = 8'h44;
    tick();
    src = 8'h00;
    tick();
    tick();
    n_checks++;
    if (irq_id !== 4'h0) begin
      n_fail++;
      $display("FAIL prio_latency: got %h expected 0", irq_id);
    end
    tick();
    n_checks++;
    if (irq_id !== 4'hA || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL prio_both: got irq=%b id=%h expected 1/a", irq, irq_id);
    end
    bus_write(0, 32'h04);
    tick();
    n_checks++;
    if (irq_id !== 4'hE) begin
      n_fail++;
      $display("FAIL prio_six: got %h expected e", irq_id);
    end
    bus_write(0, 32'h40);
    tick();
    n_checks++;
    if (irq_id !== 4'h0 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_none: got irq=%b id=%h expected 0/0", irq, irq_id);
    end
  endtask

  task automatic test_collision_swtrig();
    logic [31:0] e;
    src[0] = 1'b1;
    tick();
    src[0] = 1'b0;
    tick();
    bus_write(0, 32'h01);
    issue_read(0, 32'h01);
    e = rd_q.pop_front();
    n_checks++;
    if (data_rd !== e) begin
      n_fail++;
      $display("FAIL collision_set_wins: got %h expected %h", data_rd, e);
    end
    bus_write(0, 32'h01);
    bus_write(5, 32'h10);
    issue_read(0, 32'h10);
    e = rd_q.pop_front();
    n_checks++;
    if (data_rd !== e) begin
      n_fail++;
      $display("FAIL swtrig_edge: got %h expected %h", data_rd, e);
    end
    issue_read(4, 32'h8000_0004);
    e = rd_q.pop_front();
    n_checks++;
    if (data_rd !== e) begin
      n_fail++;
      $display("FAIL swtrig_active: got %h expected %h", data_rd, e);
    end
    issue_read(5, 32'h0);
    e = rd_q.pop_front();
    n_checks++;
    if (data_rd !== e) begin
      n_fail++;
      $display("FAIL swtrig_readback: got %h expected %h", data_rd, e);
    end
    bus_write(2, 32'hDF);
    bus_write(5, 32'h20);
    issue_read(0, 32'h10);
    e = rd_q.pop_front();
    n_checks++;
    if (data_rd !== e) begin
      n_fail++;
      $display("FAIL swtrig_level_ignored: got %h expected %h", data_rd, e);
    end
    bus_write(0, 32'h10);
    issue_read(0, 32'h0);
    e = rd_q.pop_front();
    n_checks++;
    if (data_rd !== e) begin
      n_fail++;
      $display("FAIL swtrig_clear: got %h expected %h", data_rd, e);
    end
  endtask

  task automatic test_mask_reset();
    logic [31:0] e;
    bus_write(1, 32'h00);
    bus_write(2, 32'hFF);
    bus_write(5, 32'h04);
    tick();
    tick();
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL mask_irq: got %b expected 0", irq);
    end
    issue_read(0, 32'h04);
    e = rd_q.pop_front();
    n_checks++;
    if (data_rd !== e) begin
      n_fail++;
      $display("FAIL mask_pending: got %h expected %h", data_rd, e);
    end
    bus_write(1, 32'h04);
    n_checks++;
    if (data_rd !== 32'h0 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL read_during_write: got data=%h irq=%b expected 0/0", data_rd, irq);
    end
    tick();
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL unmask_irq: got %b expected 1", irq);
    end
    src = 8'hFF;
    repeat (4) tick();
    reset = 1'b1;
    repeat (2) tick();
    n_checks++;
    if ({irq, irq_id, data_rd} !== 37'h0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got irq=%b id=%h data=%h expected all 0", irq, irq_id, data_rd);
    end
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      issue_read((k < 2) ? 0 : k - 1, 32'h0);
      e = rd_q.pop_front();
      n_checks++;
      if (data_rd !== e) begin
        n_fail++;
        $display("FAIL midreset_read%0d: got %h expected %h", k, data_rd, e);
      end
    end
    issue_read(0, 32'hFF);
    e = rd_q.pop_front();
    n_checks++;
    if (data_rd !== e) begin
      n_fail++;
      $display("FAIL postreset_level: got %h expected %h", data_rd, e);
    end
    src = 8'h00;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_edge();
    test_level();
    test_priority();
    test_collision_swtrig();
    test_mask_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
